// File: rtl/lbus_decoder.sv
// ---------------------------------------------------------------------------
// lbus_decoder
//
// Local-bus decoder and response sequencer between the core data-memory port
// and up to NSLV peripheral slaves. Each access is decoded against a table of
// base/mask pairs, forwarded to the selected slave, and held until that slave
// raises its ready or a watchdog expires. Unmapped and stalled accesses
// complete with an error response. All outputs come from flops.
//
// Optional feature (compile-time macro LBUS_ERRLOG_EN):
//   When defined, a sticky log records the address and cause of the first
//   faulting access until err_clr. When undefined, the log ports read as zero
//   and no log storage exists.
//
// Parameters:
//   XLEN      bus address/data width
//   NSLV      number of slave regions (1..8)
//   SLV_BASE  packed base addresses, slot i at [i*XLEN +: XLEN]
//   SLV_MASK  packed decode masks, same packing
//   TIMEOUT   max ACCESS cycles before abort (2..255)
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   m_req/m_addr/m_wdata/m_we
//                        master request (sampled only while idle)
//   m_busy               high whenever an access is in flight
//   m_ready/m_err/m_rdata
//                        one-cycle completion strobe with status and data
//   s_sel/s_addr/s_wdata/s_we
//                        slave-side select and latched request
//   s_rdata/s_ready      packed slave read data and per-slave ready
//   err_clr              clears the error log
//   err_valid/err_addr/err_cause
//                        error log contents (01 unmapped, 10 timeout)
// ---------------------------------------------------------------------------
module lbus_decoder #(
    parameter int                   XLEN     = 32,
    parameter int                   NSLV     = 4,
    parameter logic [NSLV*XLEN-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*XLEN-1:0] SLV_MASK = {NSLV{32'hF000_0000}},
    parameter int                   TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // master side
    input  logic                 m_req,
    input  logic [XLEN-1:0]      m_addr,
    input  logic [XLEN-1:0]      m_wdata,
    input  logic [2:0]           m_we,
    output logic                 m_busy,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [XLEN-1:0]      m_rdata,
    // slave side
    output logic [NSLV-1:0]      s_sel,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    output logic [2:0]           s_we,
    input  logic [NSLV*XLEN-1:0] s_rdata,
    input  logic [NSLV-1:0]      s_ready,
    // error log
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [XLEN-1:0]      err_addr,
    output logic [1:0]           err_cause
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;

    // next values for the registered outputs
    logic            busy_d, ready_d, err_d;
    logic [XLEN-1:0] rdata_d, addr_d, wdata_d;
    logic [NSLV-1:0] sel_d;
    logic [2:0]      we_d;
    logic [1:0]      cause_d;

    // -----------------------------------------------------------------------
    // Address decode. Scanning from the top slot down lets the lowest
    // matching index overwrite higher ones, so overlaps resolve to the lowest.
    // -----------------------------------------------------------------------
    logic            hit_any;
    logic [IW-1:0]   hit_idx;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Only the selected slave's ready and data matter.
    logic            sel_ready;
    logic [XLEN-1:0] sel_rdata;

    assign sel_ready = s_ready[idx_q];
    assign sel_rdata = s_rdata[idx_q*XLEN +: XLEN];

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so every port is driven straight from a flop.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        err_d   = m_err;
        rdata_d = m_rdata;
        sel_d   = '0;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        we_d    = 3'b000;
        cause_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (m_req) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    if (hit_any) begin
                        state_d        = ACCESS;
                        idx_d          = hit_idx;
                        cnt_d          = '0;
                        sel_d[hit_idx] = 1'b1;
                        we_d           = m_we;
                    end else begin
                        // no slave is ever selected for an unmapped address
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        cause_d = CAUSE_UNMAPPED;
                    end
                end
            end

            ACCESS: begin
                sel_d = s_sel;
                we_d  = s_we;
                if (sel_ready) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    // writes return zero so stale slave data never leaks out
                    rdata_d = (s_we == 3'b000) ? sel_rdata : '0;
                    sel_d   = '0;
                    we_d    = 3'b000;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // counter started at 0 on entry, so this is the
                    // TIMEOUT-th cycle with the slave selected
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    sel_d   = '0;
                    we_d    = 3'b000;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            s_sel   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= 3'b000;
        end else begin
            m_busy  <= busy_d;
            m_ready <= ready_d;
            m_err   <= err_d;
            m_rdata <= rdata_d;
            s_sel   <= sel_d;
            s_addr  <= addr_d;
            s_wdata <= wdata_d;
            s_we    <= we_d;
        end
    end

    // -----------------------------------------------------------------------
    // Error log. The entry is written on the same edge that raises m_ready,
    // so err_valid appears together with the faulting response.
    // -----------------------------------------------------------------------
`ifdef LBUS_ERRLOG_EN
    logic err_evt;
    assign err_evt = ready_d & err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cause <= 2'b00;
        end else if (err_evt && (!err_valid || err_clr)) begin
            // a fault arriving with a clear wins over the clear
            err_valid <= 1'b1;
            err_addr  <= addr_d;
            err_cause <= cause_d;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cause <= 2'b00;
        end
    end
`else
    assign err_valid = 1'b0;
    assign err_addr  = '0;
    assign err_cause = 2'b00;

    logic unused_errlog;
    assign unused_errlog = &{1'b0, err_clr, cause_d};
`endif

endmodule

// File: tb/tb_lbus_decoder.sv
// Directed bench for lbus_decoder: a main instance with default decode and a
// second instance whose slots 0 and 1 overlap. Responses are checked against
// a scoreboard queue filled when each request is driven.
module tb_lbus_decoder;

`ifdef LBUS_ERRLOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req;
    logic [31:0]  m_addr, m_wdata;
    logic [2:0]   m_we;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic         err_clr;

    logic         m_busy, m_ready, m_err;
    logic [31:0]  m_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]   s_sel;
    logic [2:0]   s_we;
    logic         err_valid;
    logic [1:0]   err_cause;

    logic         o_busy, o_ready, o_err, o_evalid;
    logic [31:0]  o_rdata, o_saddr, o_swdata, o_eaddr;
    logic [3:0]   o_sel;
    logic [2:0]   o_we;
    logic [1:0]   o_ecause;

    always #5 clk = ~clk;

    lbus_decoder dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_busy(m_busy), .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
        .err_cause(err_cause)
    );

    lbus_decoder #(
        .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000})
    ) u_ovl (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_busy(o_busy), .m_ready(o_ready), .m_err(o_err), .m_rdata(o_rdata),
        .s_sel(o_sel), .s_addr(o_saddr), .s_wdata(o_swdata), .s_we(o_we),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .err_valid(o_evalid), .err_addr(o_eaddr),
        .err_cause(o_ecause)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input logic v, input logic [31:0] a, input logic [1:0] c);
        chk({tag, "_ev"}, 32'(err_valid), LOG ? 32'(v) : 32'd0);
        chk({tag, "_ea"}, err_addr,       LOG ? a : 32'd0);
        chk({tag, "_ec"}, 32'(err_cause), LOG ? 32'(c) : 32'd0);
    endtask

    // response monitor for the main instance
    always @(negedge clk) begin
        if (m_ready) begin
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_err", 32'(m_err), 32'(e.err));
                chk("sb_rdata", m_rdata, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_we = 3'b000;
        s_rdata = '0; s_ready = '0; err_clr = 1'b0;
        repeat (3) cyc();
        smp();
        chk("rst_busy",  32'(m_busy), 32'd0);
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_sel",   32'(s_sel), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk_log("rst", 1'b0, 32'd0, 2'b00);
        cyc(); rst = 1'b0;

        // read slot 1, ready in the first ACCESS cycle
        cyc();
        m_req = 1'b1; m_addr = 32'h1000_0010; m_we = 3'b000;
        s_ready = 4'b0010; s_rdata[32 +: 32] = 32'hDEAD_BEEF;
        sb.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        cyc(); m_req = 1'b0; smp();
        chk("rd_sel",   32'(s_sel), 32'h2);
        chk("rd_addr",  s_addr, 32'h1000_0010);
        chk("rd_busy",  32'(m_busy), 32'd1);
        chk("rd_ready0", 32'(m_ready), 32'd0);
        cyc(); smp();
        chk("rd_ready", 32'(m_ready), 32'd1);
        chk("rd_sel0",  32'(s_sel), 32'd0);

        // back-to-back read accepted the cycle after RESP
        cyc();
        m_req = 1'b1; m_addr = 32'h1000_0020; s_rdata[32 +: 32] = 32'h1234_5678;
        sb.push_back('{err: 1'b0, rdata: 32'h1234_5678});
        smp();
        chk("b2b_busy0", 32'(m_busy), 32'd0);
        chk("b2b_hold",  m_rdata, 32'hDEAD_BEEF);
        cyc(); m_req = 1'b0; smp();
        chk("b2b_sel", 32'(s_sel), 32'h2);
        cyc(); smp();
        chk("b2b_ready", 32'(m_ready), 32'd1);

        // write slot 2 with three wait states
        cyc();
        s_ready = 4'b0000; s_rdata[64 +: 32] = 32'hAAAA_5555;
        m_req = 1'b1; m_addr = 32'h2000_0008; m_wdata = 32'hCAFE_0001; m_we = 3'b111;
        sb.push_back('{err: 1'b0, rdata: 32'h0});
        for (int k = 1; k <= 4; k++) begin
            cyc(); m_req = 1'b0;
            if (k == 4) s_ready = 4'b0100;
            smp();
            chk("wr_sel",   32'(s_sel), 32'h4);
            chk("wr_we",    32'(s_we), 32'h7);
            chk("wr_ready", 32'(m_ready), 32'd0);
        end
        chk("wr_wdata", s_wdata, 32'hCAFE_0001);
        cyc(); s_ready = 4'b0000; m_we = 3'b000; smp();
        chk("wr_done",  32'(m_ready), 32'd1);
        chk("wr_we0",   32'(s_we), 32'd0);

        // unmapped access
        cyc();
        m_req = 1'b1; m_addr = 32'h7000_0000;
        sb.push_back('{err: 1'b1, rdata: 32'h0});
        cyc(); m_req = 1'b0; smp();
        chk("um_ready", 32'(m_ready), 32'd1);
        chk("um_sel",   32'(s_sel), 32'd0);
        chk_log("um", 1'b1, 32'h7000_0000, 2'b01);
        cyc(); smp();
        chk("um_idle", 32'(m_busy), 32'd0);

        // timeout on slot 3 while other slaves are ready; log already full
        cyc();
        m_req = 1'b1; m_addr = 32'h3000_0004; s_ready = 4'b1011 & 4'b0111;
        sb.push_back('{err: 1'b1, rdata: 32'h0});
        for (int k = 1; k <= 16; k++) begin
            cyc(); m_req = 1'b0; smp();
            chk("to_sel", 32'(s_sel), 32'h8);
        end
        cyc(); smp();
        chk("to_ready", 32'(m_ready), 32'd1);
        chk("to_sel0",  32'(s_sel), 32'd0);
        chk_log("to_keep", 1'b1, 32'h7000_0000, 2'b01);

        // clear the log
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; smp();
        chk_log("clr", 1'b0, 32'd0, 2'b00);

        // timeout again into an empty log
        cyc();
        m_req = 1'b1; m_addr = 32'h3000_0000;
        sb.push_back('{err: 1'b1, rdata: 32'h0});
        repeat (17) begin
            cyc(); m_req = 1'b0;
        end
        smp();
        chk("to2_ready", 32'(m_ready), 32'd1);
        chk_log("to2", 1'b1, 32'h3000_0000, 2'b10);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0; s_ready = 4'b0000;

        // overlapping slots: lowest index wins, ready[1] ignored
        cyc();
        m_req = 1'b1; m_addr = 32'h0000_0000; s_rdata[0 +: 32] = 32'hCAFE_F00D;
        sb.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
        cyc(); m_req = 1'b0; s_ready = 4'b0010; smp();
        chk("ov_sel1", 32'(o_sel), 32'h1);
        cyc(); smp();
        chk("ov_sel2",  32'(o_sel), 32'h1);
        chk("ov_ready0", 32'(o_ready), 32'd0);
        cyc(); s_ready = 4'b0001; smp();
        chk("ov_sel3", 32'(o_sel), 32'h1);
        cyc(); s_ready = 4'b0000; smp();
        chk("ov_ready", 32'(o_ready), 32'd1);
        chk("ov_rdata", o_rdata, 32'hCAFE_F00D);
        chk("ov_err",   32'(o_err), 32'd0);

        // reset during ACCESS; a request while busy is dropped
        cyc();
        m_req = 1'b1; m_addr = 32'h1000_0000;
        cyc(); m_addr = 32'h2000_0000; smp();
        chk("rs_sel", 32'(s_sel), 32'h2);
        cyc(); m_req = 1'b0; rst = 1'b1; smp();
        chk("rs_drop", s_addr, 32'h1000_0000);
        cyc(); rst = 1'b0; smp();
        chk("rs_busy",  32'(m_busy), 32'd0);
        chk("rs_ready", 32'(m_ready), 32'd0);
        chk("rs_err",   32'(m_err), 32'd0);
        chk("rs_rdata", m_rdata, 32'd0);
        chk("rs_sel0",  32'(s_sel), 32'd0);
        chk("rs_addr",  s_addr, 32'd0);
        chk("rs_wdata", s_wdata, 32'd0);
        chk("rs_we",    32'(s_we), 32'd0);
        chk_log("rs", 1'b0, 32'd0, 2'b00);
        repeat (3) begin
            cyc(); smp();
            chk("rs_noready", 32'(m_ready), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
